// File: rtl/msgmii_rst_pkg.sv
// Shared types and sizing helpers for the MSGMII/TSE reset sequencer.
// Widths here are derived from the default parameters; modules re-derive from their own.
package msgmii_rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_REL,
        ST_RUN
    } seq_state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Width of a counter spanning 0..count-1, never narrower than one bit.
    function automatic int cnt_width(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGGER     = 8;
    localparam int DEF_DIV         = 2;

    localparam int DEF_HOLD_W = cnt_width(DEF_HOLD_CYCLES);
    localparam int DEF_STG_W  = cnt_width(DEF_STAGGER);
    localparam int DEF_DIV_W  = cnt_width(DEF_DIV);

endpackage

// File: rtl/msgmii_rst_sync.sv
// Async-assert / sync-deassert reset synchroniser; output is high while in reset.
// Reusable across the TSE clock domains.
module msgmii_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic sync_rst
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state uses <= so each stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = sync_q[STAGES-1];

endmodule

// File: rtl/msgmii_rst_seq.sv
// Reset sequencer: synchronised hold, staggered per-channel release, software
// re-sequencing, test-mode bypass and a divided clock-enable gated by channel 0.
module msgmii_rst_seq
    import msgmii_rst_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGGER     = DEF_STAGGER,
    parameter int DIV         = DEF_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_mode,
    input  logic              sw_rst_req,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] rst_out,
    output logic              seq_done,
    output logic              clk_en_div
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int STG_W  = cnt_width(STAGGER);
    localparam int SLOT_W = cnt_width(NUM_CH);
    localparam int DIV_W  = cnt_width(DIV);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);

    logic              sync_rst;
    seq_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [STG_W-1:0]  stg_cnt_q, stg_cnt_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              stb_q, stb_d;
    logic              div_hold;

    msgmii_rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .sync_rst (sync_rst)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            stg_cnt_q  <= '0;
            slot_q     <= '0;
            rst_q      <= '1;
            div_cnt_q  <= '0;
            stb_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            stg_cnt_q  <= stg_cnt_d;
            slot_q     <= slot_d;
            rst_q      <= rst_d;
            div_cnt_q  <= div_cnt_d;
            stb_q      <= stb_d;
        end
    end

    // NOTE: every signal gets its default first so no branch leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stg_cnt_d  = stg_cnt_q;
        slot_d     = slot_q;
        rst_d      = rst_q;

        case (state_q)
            ST_HOLD: begin
                rst_d     = '1;
                stg_cnt_d = '0;
                slot_d    = '0;
                if (sw_rst_req) begin
                    hold_cnt_d = '0;
                end else if (!sync_rst) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = ST_REL;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end

            ST_REL: begin
                if (sw_rst_req) begin
                    state_d    = ST_HOLD;
                    rst_d      = '1;
                    hold_cnt_d = '0;
                    stg_cnt_d  = '0;
                    slot_d     = '0;
                end else begin
                    // Current and earlier slots track their enables; a disabled slot still burns its time.
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (i <= int'(slot_q)) begin
                            rst_d[i] = ~ch_en[i];
                        end
                    end
                    if (slot_q == SLOT_LAST) begin
                        state_d   = ST_RUN;
                        stg_cnt_d = '0;
                    end else if (stg_cnt_q == STG_LAST) begin
                        stg_cnt_d = '0;
                        slot_d    = slot_q + 1'b1;
                    end else begin
                        stg_cnt_d = stg_cnt_q + 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (sw_rst_req) begin
                    state_d    = ST_HOLD;
                    rst_d      = '1;
                    hold_cnt_d = '0;
                    stg_cnt_d  = '0;
                    slot_d     = '0;
                end else begin
                    rst_d = ~ch_en;
                end
            end

            default: begin
                state_d = ST_HOLD;
                rst_d   = '1;
            end
        endcase
    end

    // Holding on the next value as well keeps the strobe low on the edge channel 0 re-enters reset.
    assign div_hold = rst_q[0] | rst_d[0];

    always_comb begin
        div_cnt_d = div_cnt_q;
        stb_d     = 1'b0;
        if (div_hold) begin
            div_cnt_d = '0;
        end else begin
            stb_d     = (div_cnt_q == DIV_LAST);
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        end
    end

    assign rst_out    = test_mode ? ({NUM_CH{rst}} | ~ch_en) : rst_q;
    assign seq_done   = (state_q == ST_RUN);
    assign clk_en_div = stb_q;

endmodule

// File: tb/tb_msgmii_rst_seq.sv
// Bench for msgmii_rst_seq: directed timing pins plus randomized traffic, all checked
// every cycle against a release-time model (DIV=2 and DIV=5 instances in parallel).
module tb_msgmii_rst_seq;

    localparam int N   = 4;
    localparam int S   = 2;
    localparam int H   = 16;
    localparam int STG = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         test_mode = 1'b0;
    logic         sw_rst_req = 1'b0;
    logic [N-1:0] ch_en = '1;

    logic [N-1:0] rst_out2, rst_out5;
    logic         seq_done2, seq_done5;
    logic         clk_en2, clk_en5;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    msgmii_rst_seq #(
        .NUM_CH (N), .SYNC_STAGES (S), .HOLD_CYCLES (H), .STAGGER (STG), .DIV (2)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .test_mode  (test_mode),
        .sw_rst_req (sw_rst_req),
        .ch_en      (ch_en),
        .rst_out    (rst_out2),
        .seq_done   (seq_done2),
        .clk_en_div (clk_en2)
    );

    msgmii_rst_seq #(
        .NUM_CH (N), .SYNC_STAGES (S), .HOLD_CYCLES (H), .STAGGER (STG), .DIV (5)
    ) dut5 (
        .clk        (clk),
        .rst        (rst),
        .test_mode  (test_mode),
        .sw_rst_req (sw_rst_req),
        .ch_en      (ch_en),
        .rst_out    (rst_out5),
        .seq_done   (seq_done5),
        .clk_en_div (clk_en5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: a sequence "starts" at an edge; channel i releases at start+1+H+i*STG.
    bit           m_in_rst = 1'b1;
    int           m_start  = 0;
    logic [N-1:0] m_int    = '1;
    int           m_fall   = 0;
    bit           m_prev0  = 1'b1;

    function automatic bit exp_strobe(input int div);
        return (!m_int[0] && (cyc - m_fall) >= div && ((cyc - m_fall) % div) == 0);
    endfunction

    always @(posedge clk) begin : model
        logic [N-1:0] exp_out;
        bit           exp_done;
        bit           exp_s2, exp_s5;
        cyc++;
        exp_done = 1'b0;
        if (rst) begin
            m_in_rst = 1'b1;
            m_int    = '1;
        end else begin
            if (m_in_rst) begin
                m_in_rst = 1'b0;
                m_start  = cyc + S - 1;
            end
            if (sw_rst_req && cyc > m_start) begin
                m_start = cyc;
            end
            for (int i = 0; i < N; i++) begin
                m_int[i] = (cyc < m_start + 1 + H + i * STG) ? 1'b1 : ~ch_en[i];
            end
            exp_done = (cyc >= m_start + 1 + H + (N - 1) * STG);
        end
        if (m_prev0 && !m_int[0]) begin
            m_fall = cyc;
        end
        m_prev0 = m_int[0];
        exp_s2  = exp_strobe(2);
        exp_s5  = exp_strobe(5);
        exp_out = test_mode ? ({N{rst}} | ~ch_en) : m_int;
        #1;
        check("model rst_out d2", 32'(rst_out2), 32'(exp_out));
        check("model rst_out d5", 32'(rst_out5), 32'(exp_out));
        check("model seq_done d2", 32'(seq_done2), 32'(exp_done));
        check("model seq_done d5", 32'(seq_done5), 32'(exp_done));
        check("model clk_en d2", 32'(clk_en2), 32'(exp_s2));
        check("model clk_en d5", 32'(clk_en5), 32'(exp_s5));
    end

    // Targets are computed edge numbers, so this never waits on the DUT.
    task automatic wait_cyc(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k, p, q;
        int rst_left;

        // Power-on reset, asynchronous effect.
        #2 rst = 1'b1;
        #1;
        check("por rst_out", 32'(rst_out2), 32'h0000000f);
        check("por seq_done", 32'(seq_done2), 32'h0);
        check("por clk_en", 32'(clk_en2), 32'h0);
        repeat (5) @(posedge clk);

        // Default release sequence and divider start-up.
        @(negedge clk);
        rst = 1'b0;
        k = cyc + 1;
        wait_cyc(k + 17); check("seq k+17", 32'(rst_out2), 32'hf);
        wait_cyc(k + 18); check("seq k+18", 32'(rst_out2), 32'he);
                          check("div2 k+18", 32'(clk_en2), 32'h0);
        wait_cyc(k + 19); check("div2 k+19", 32'(clk_en2), 32'h0);
        wait_cyc(k + 20); check("div2 k+20", 32'(clk_en2), 32'h1);
        wait_cyc(k + 21); check("div2 k+21", 32'(clk_en2), 32'h0);
        wait_cyc(k + 22); check("div5 k+22", 32'(clk_en5), 32'h0);
        wait_cyc(k + 23); check("div5 k+23", 32'(clk_en5), 32'h1);
        wait_cyc(k + 26); check("seq k+26", 32'(rst_out2), 32'hc);
        wait_cyc(k + 34); check("seq k+34", 32'(rst_out2), 32'h8);
        wait_cyc(k + 41); check("done k+41", 32'(seq_done2), 32'h0);
        wait_cyc(k + 42); check("seq k+42", 32'(rst_out2), 32'h0);
                          check("done k+42", 32'(seq_done2), 32'h1);

        // Software reset in RUN.
        @(negedge clk);
        sw_rst_req = 1'b1;
        p = cyc + 1;
        wait_cyc(p);
        sw_rst_req = 1'b0;
        check("sw rst_out", 32'(rst_out2), 32'hf);
        check("sw seq_done", 32'(seq_done2), 32'h0);
        wait_cyc(p + 16); check("sw p+16", 32'(rst_out2), 32'hf);
        wait_cyc(p + 17); check("sw p+17", 32'(rst_out2), 32'he);

        // Second pulse at hold cycle 10 restarts the hold.
        @(negedge clk);
        sw_rst_req = 1'b1;
        p = cyc + 1;
        wait_cyc(p);
        sw_rst_req = 1'b0;
        q = p + 11;
        wait_cyc(q - 1);
        sw_rst_req = 1'b1;
        wait_cyc(q);
        sw_rst_req = 1'b0;
        wait_cyc(p + 17); check("sw2 old release", 32'(rst_out2), 32'hf);
        wait_cyc(q + 16); check("sw2 q+16", 32'(rst_out2), 32'hf);
        wait_cyc(q + 17); check("sw2 q+17", 32'(rst_out2), 32'he);

        // Channel 2 disabled through the sequence, then enabled in RUN.
        @(negedge clk);
        rst   = 1'b1;
        ch_en = 4'b1011;
        @(negedge clk);
        rst = 1'b0;
        k = cyc + 1;
        wait_cyc(k + 34); check("en k+34", 32'(rst_out2), 32'hc);
        wait_cyc(k + 41); check("en k+41", 32'(rst_out2), 32'hc);
        wait_cyc(k + 42); check("en k+42", 32'(rst_out2), 32'h4);
                          check("en done", 32'(seq_done2), 32'h1);
        ch_en = 4'b1111;
        @(negedge clk);
        check("en raise", 32'(rst_out2), 32'h0);
        check("en raise done", 32'(seq_done2), 32'h1);

        // Asynchronous reset mid-REL.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        k = cyc + 1;
        wait_cyc(k + 27); check("rel k+27", 32'(rst_out2), 32'hc);
        rst = 1'b1;
        #1;
        check("rel async rst_out", 32'(rst_out2), 32'hf);
        check("rel async done", 32'(seq_done2), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        k = cyc + 1;
        wait_cyc(k + 17); check("rel re k+17", 32'(rst_out2), 32'hf);
        wait_cyc(k + 18); check("rel re k+18", 32'(rst_out2), 32'he);

        // Test-mode bypass.
        @(negedge clk);
        rst       = 1'b1;
        test_mode = 1'b1;
        ch_en     = 4'b0101;
        #1; check("tm rst hi", 32'(rst_out2), 32'hf);
        @(negedge clk);
        rst = 1'b0;
        #1; check("tm rst lo", 32'(rst_out2), 32'ha);
        repeat (3) @(negedge clk);
        check("tm hold", 32'(rst_out2), 32'ha);
        rst = 1'b1;
        #1; check("tm rst hi2", 32'(rst_out2), 32'hf);
        @(negedge clk);
        test_mode = 1'b0;
        ch_en     = '1;
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic; test_mode only changes as rst asserts.
        rst_left = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (rst_left > 0) begin
                rst_left--;
            end else if ($urandom_range(299) == 0) begin
                rst_left = $urandom_range(4, 1);
                if ($urandom_range(3) == 0) test_mode = ~test_mode;
            end
            rst        = (rst_left > 0);
            sw_rst_req = ($urandom_range(79) == 0);
            if ($urandom_range(15) == 0) ch_en = N'($urandom);
        end
        @(negedge clk);
        sw_rst_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
